pc_fetch_sequencer: RTL

- Owns the architectural fetch PC and sequences instruction fetch over a req/ack instruction-memory handshake.
- Arbitrates next-PC sources: trap, EX-stage redirect (branch/jal/jalr), hazard stall, sequential +4.
- Generates pipeline flush pulses.
- Sits in the IF stage, between the hazard unit, the EX stage and the instruction memory port.

---
 rtl/pc_fetch_sequencer_pkg.sv | 22 ++
 rtl/pc_fetch_sequencer_if.sv | 9 +
 rtl/pc_fetch_sequencer_redirect_target_calc.sv | 28 ++
 rtl/pc_fetch_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared encodings for the IF-stage fetch sequencer: next-PC operations,
// sequencer states and the sequential PC step.
package pc_fetch_sequencer_pkg;

    localparam logic [4:0] NPC_PLUS4  = 5'd0;
    localparam logic [4:0] NPC_BRANCH = 5'd1;
    localparam logic [4:0] NPC_JUMP   = 5'd2;
    localparam logic [4:0] NPC_JALR   = 5'd3;

    typedef enum logic [1:0] {
        PCS_BOOT  = 2'd0,
        PCS_FETCH = 2'd1,
        PCS_WAIT  = 2'd2,
        PCS_HOLD  = 2'd3
    } pcs_e;

    // 32-bit wrap is intentional; fetch simply rolls over to address 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory req/ack fetch port; the sequencer is master, memory is slave.
interface pc_fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master(output imem_req, output imem_addr, input imem_ack);
    modport slave (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_sequencer_redirect_target_calc.sv
// Decodes an EX-stage control transfer into redirect/target/misalign.
// A target with bit 1 set is replaced by the trap vector.
module redirect_target_calc
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        ex_valid,
    input  logic [4:0]  ex_npc_op,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_out,
    output logic        ex_redir,
    output logic [31:0] target,
    output logic        misalign
);
    logic [31:0] raw_target;

    always_comb begin
        raw_target = ex_pc + ex_imm;
        if (ex_npc_op == NPC_JALR) raw_target = ex_alu_out & ~32'h1;
        ex_redir = ex_valid & (((ex_npc_op == NPC_BRANCH) & ex_branch_taken) |
                               (ex_npc_op == NPC_JUMP) | (ex_npc_op == NPC_JALR));
        misalign = ex_redir & raw_target[1];
        target   = raw_target[1] ? TRAP_VEC : raw_target;
    end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// IF-stage fetch PC owner: arbitrates trap/redirect/stall/sequential next-PC
// and runs the req/ack instruction-memory handshake.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 ex_valid,
    input  logic [4:0]           ex_npc_op,
    input  logic                 ex_branch_taken,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_imm,
    input  logic [31:0]          ex_alu_out,
    input  logic                 trap_req,
    pc_fetch_sequencer_if.master imem,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 misalign_o
);
    pcs_e        state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic        ex_redir, calc_misalign, take, req;
    logic [31:0] ex_target, take_target;

    redirect_target_calc #(.TRAP_VEC(TRAP_VEC)) u_calc (
        .ex_valid       (ex_valid),
        .ex_npc_op      (ex_npc_op),
        .ex_branch_taken(ex_branch_taken),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_alu_out     (ex_alu_out),
        .ex_redir       (ex_redir),
        .target         (ex_target),
        .misalign       (calc_misalign)
    );

    // Gating with rst makes the combinational pulses show reset values immediately.
    assign take        = !rst && (trap_req || ex_redir);
    assign take_target = trap_req ? TRAP_VEC : ex_target;
    assign req         = (state_q == PCS_WAIT) ||
                         ((state_q == PCS_FETCH) && !stall_i && !take);

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;
    assign if_pc          = fetch_pc_q;
    assign flush_if_id    = take;
    assign flush_id_ex    = take;
    assign misalign_o     = !rst && calc_misalign;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if_valid      = 1'b0;
        unique case (state_q)
            PCS_BOOT: begin
                state_d = PCS_FETCH;
                if (take) fetch_pc_d = take_target;
            end
            PCS_FETCH: begin
                if (take) fetch_pc_d = take_target;
                else if (req && imem.imem_ack) begin
                    if_valid   = 1'b1;
                    fetch_pc_d = pc_plus4(fetch_pc_q);
                end else if (req) state_d = PCS_WAIT;
            end
            PCS_WAIT: begin
                if (imem.imem_ack) begin
                    state_d      = PCS_FETCH;
                    pend_valid_d = 1'b0;
                    // Any redirect seen during the access discards the returned word.
                    if (take) fetch_pc_d = take_target;
                    else if (pend_valid_q) fetch_pc_d = pend_target_q;
                    else begin
                        if_valid = 1'b1;
                        if (stall_i) state_d = PCS_HOLD;
                        else fetch_pc_d = pc_plus4(fetch_pc_q);
                    end
                end else if (take) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = take_target;
                end
            end
            PCS_HOLD: begin
                if_valid = !take;
                if (take) begin
                    fetch_pc_d = take_target;
                    state_d    = PCS_FETCH;
                end else if (!stall_i) begin
                    fetch_pc_d = pc_plus4(fetch_pc_q);
                    state_d    = PCS_FETCH;
                end
            end
            default: state_d = PCS_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PCS_BOOT;
            fetch_pc_q    <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end
endmodule
